// File: rtl/mig_ui_model.sv
// Block-RAM stand-in for the MIG 7-series app_* user interface: calibration delay,
// single-beat 128-bit writes with byte masks, fixed-latency pipelined reads, optional ready stalls.
module mig_ui_model #(
    parameter int DEPTH_LOG2   = 10,
    parameter int RD_LATENCY   = 4,
    parameter int CALIB_CYCLES = 64,
    parameter int STALL_EVERY  = 0
) (
    input  logic         ui_clk,
    input  logic         rst,
    input  logic [26:0]  app_addr,
    input  logic [2:0]   app_cmd,
    input  logic         app_en,
    output logic         app_rdy,
    input  logic [127:0] app_wdf_data,
    input  logic [15:0]  app_wdf_mask,
    input  logic         app_wdf_wren,
    input  logic         app_wdf_end,
    output logic         app_wdf_rdy,
    output logic [127:0] app_rd_data,
    output logic         app_rd_data_valid,
    output logic         app_rd_data_end,
    output logic         init_calib_complete
);

    localparam int         DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    logic [15:0]           calib_cnt_reg;
    logic                  calib_reg;
    logic                  wcmd_pend_reg;
    logic                  wdata_pend_reg;
    logic [DEPTH_LOG2-1:0] widx_reg;
    logic [127:0]          wdata_reg;
    logic [15:0]           wmask_reg;
    logic [127:0]          mem [DEPTH];
    logic [RD_LATENCY-1:0] vld_reg;
    logic [127:0]          dat_reg [RD_LATENCY];

    logic                  stall;
    logic [DEPTH_LOG2-1:0] cmd_idx;
    logic                  cmd_acc;
    logic                  wr_cmd_acc;
    logic                  rd_acc;
    logic                  data_acc;
    logic                  commit;
    logic                  unused_addr_bits;

    // Address is in 16-bit units; one stored word spans eight of them, upper bits alias.
    assign cmd_idx          = app_addr[3 +: DEPTH_LOG2];
    assign unused_addr_bits = ^{app_addr[2:0], app_addr[26:3+DEPTH_LOG2]};

    assign app_rdy     = calib_reg & ~wcmd_pend_reg & ~stall;
    assign app_wdf_rdy = calib_reg & ~wdata_pend_reg;
    assign cmd_acc     = app_en & app_rdy;
    assign wr_cmd_acc  = cmd_acc & (app_cmd == CMD_WRITE);
    assign rd_acc      = cmd_acc & (app_cmd == CMD_READ);
    assign data_acc    = app_wdf_wren & app_wdf_end & app_wdf_rdy;
    assign commit      = wcmd_pend_reg & wdata_pend_reg;

    always_ff @(posedge ui_clk or negedge rst) begin
        if (!rst) begin
            calib_cnt_reg <= '0;
            calib_reg     <= 1'b0;
        end else if (!calib_reg) begin
            calib_cnt_reg <= calib_cnt_reg + 16'd1;
            if (calib_cnt_reg + 16'd1 == 16'(CALIB_CYCLES))
                calib_reg <= 1'b1;
        end
    end

    generate
        if (STALL_EVERY == 0) begin : g_no_stall
            assign stall = 1'b0;
        end else begin : g_stall
            logic [15:0] stall_cnt_reg;
            always_ff @(posedge ui_clk or negedge rst) begin
                if (!rst)
                    stall_cnt_reg <= '0;
                else if (stall_cnt_reg == 16'(STALL_EVERY - 1))
                    stall_cnt_reg <= '0;
                else
                    stall_cnt_reg <= stall_cnt_reg + 16'd1;
            end
            assign stall = (stall_cnt_reg == 16'd0);
        end
    endgenerate

    // Both pending flags gate their own ready, so neither can be set on a commit edge.
    always_ff @(posedge ui_clk or negedge rst) begin
        if (!rst) begin
            wcmd_pend_reg  <= 1'b0;
            wdata_pend_reg <= 1'b0;
        end else begin
            if (wr_cmd_acc)
                wcmd_pend_reg <= 1'b1;
            else if (commit)
                wcmd_pend_reg <= 1'b0;
            if (data_acc)
                wdata_pend_reg <= 1'b1;
            else if (commit)
                wdata_pend_reg <= 1'b0;
        end
    end

    always_ff @(posedge ui_clk) begin
        if (wr_cmd_acc)
            widx_reg <= cmd_idx;
        if (data_acc) begin
            wdata_reg <= app_wdf_data;
            wmask_reg <= app_wdf_mask;
        end
    end

    // RAM array and read pipeline carry no reset so the array maps onto block RAM.
    always_ff @(posedge ui_clk) begin
        if (commit) begin
            for (int b = 0; b < 16; b++) begin
                if (!wmask_reg[b])
                    mem[widx_reg][b*8 +: 8] <= wdata_reg[b*8 +: 8];
            end
        end
        if (rd_acc)
            dat_reg[0] <= mem[cmd_idx];
        for (int i = 1; i < RD_LATENCY; i++)
            dat_reg[i] <= dat_reg[i-1];
    end

    generate
        if (RD_LATENCY == 1) begin : g_vld_one
            always_ff @(posedge ui_clk or negedge rst) begin
                if (!rst)
                    vld_reg <= '0;
                else
                    vld_reg <= rd_acc;
            end
        end else begin : g_vld_shift
            always_ff @(posedge ui_clk or negedge rst) begin
                if (!rst)
                    vld_reg <= '0;
                else
                    vld_reg <= {vld_reg[RD_LATENCY-2:0], rd_acc};
            end
        end
    endgenerate

    // Data is zeroed outside the valid pulse, which also yields the required reset value.
    assign app_rd_data_valid   = vld_reg[RD_LATENCY-1];
    assign app_rd_data_end     = vld_reg[RD_LATENCY-1];
    assign app_rd_data         = vld_reg[RD_LATENCY-1] ? dat_reg[RD_LATENCY-1] : '0;
    assign init_calib_complete = calib_reg;

endmodule
